// File: rtl/cpu_pkg.sv
// Shared pipeline encodings used by the decoder, memory stage and write-back stage.
package cpu_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;
    localparam logic [1:0] WB_SEL_RSVD = 2'd3;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    // Extends an 8-bit or 16-bit lane to the datapath width.
    function automatic logic [31:0] extend_lane(input logic [15:0] lane, input logic is_half,
                                                input logic sext);
        logic [31:0] res;
        if (is_half) begin
            res = sext ? {{16{lane[15]}}, lane} : {16'd0, lane};
        end else begin
            res = sext ? {{24{lane[7]}}, lane[7:0]} : {24'd0, lane[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load alignment: picks the addressed byte/half lane of a raw memory word and extends it.
module wb_load_align
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        addr,
    input  logic [1:0]        size,
    input  logic              sext,
    output logic [DATA_W-1:0] aligned
);

    logic [7:0]  byte_lane_s;
    logic [15:0] half_lane_s;

    // Lane select and extension; half loads ignore addr[0] and never trap.
    always_comb begin
        byte_lane_s = 8'd0;
        half_lane_s = 16'd0;
        aligned     = mem_data;
        case (size)
            MEM_SIZE_BYTE: begin
                byte_lane_s = mem_data[{addr, 3'b000} +: 8];
                aligned     = extend_lane({8'd0, byte_lane_s}, 1'b0, sext);
            end
            MEM_SIZE_HALF: begin
                half_lane_s = addr[1] ? mem_data[31:16] : mem_data[15:0];
                aligned     = extend_lane(half_lane_s, 1'b1, sext);
            end
            MEM_SIZE_WORD: aligned = mem_data;
            default:       aligned = mem_data;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, write-back mux, retired-instruction counter and sticky halt flag.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 32,
    parameter int LINK_OFFSET = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_reg_we,
    input  logic [4:0]        in_rd,
    input  logic [1:0]        in_wb_sel,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [1:0]        in_mem_addr,
    input  logic [1:0]        in_mem_size,
    input  logic              in_mem_sext,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              in_halt,
    output logic              rf_w_en,
    output logic [4:0]        rf_req_w,
    output logic [DATA_W-1:0] rf_data_w,
    output logic              fwd_valid,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic              halted
);

    logic              valid_r;
    logic              reg_we_r;
    logic [4:0]        rd_r;
    logic [1:0]        wb_sel_r;
    logic [DATA_W-1:0] alu_res_r;
    logic [DATA_W-1:0] mem_data_r;
    logic [1:0]        mem_addr_r;
    logic [1:0]        mem_size_r;
    logic              mem_sext_r;
    logic [DATA_W-1:0] pc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              halted_r;

    logic              step_s;
    logic              load_s;
    logic [DATA_W-1:0] aligned_s;
    logic [DATA_W-1:0] wb_data_s;

    // A halted stage is frozen exactly like en=0; flush outranks stall.
    assign step_s = en & ~halted_r;
    assign load_s = step_s & ~flush & ~stall;

    // MEM/WB pipeline register; a flush loads a fully cleared bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r    <= 1'b0;
            reg_we_r   <= 1'b0;
            rd_r       <= 5'd0;
            wb_sel_r   <= 2'd0;
            alu_res_r  <= '0;
            mem_data_r <= '0;
            mem_addr_r <= 2'd0;
            mem_size_r <= 2'd0;
            mem_sext_r <= 1'b0;
            pc_r       <= '0;
        end else if (step_s && flush) begin
            valid_r    <= 1'b0;
            reg_we_r   <= 1'b0;
            rd_r       <= 5'd0;
            wb_sel_r   <= 2'd0;
            alu_res_r  <= '0;
            mem_data_r <= '0;
            mem_addr_r <= 2'd0;
            mem_size_r <= 2'd0;
            mem_sext_r <= 1'b0;
            pc_r       <= '0;
        end else if (load_s) begin
            valid_r    <= in_valid;
            reg_we_r   <= in_reg_we;
            rd_r       <= in_rd;
            wb_sel_r   <= in_wb_sel;
            alu_res_r  <= in_alu_res;
            mem_data_r <= in_mem_data;
            mem_addr_r <= in_mem_addr;
            mem_size_r <= in_mem_size;
            mem_sext_r <= in_mem_sext;
            pc_r       <= in_pc;
        end else begin
            valid_r    <= valid_r;
        end
    end

    // Retired counter and halt flag advance only on a real, unflushed capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            halted_r <= 1'b0;
        end else if (load_s && in_valid) begin
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            halted_r <= halted_r | in_halt;
        end else begin
            cnt_r    <= cnt_r;
            halted_r <= halted_r;
        end
    end

    wb_load_align #(.DATA_W(DATA_W)) u_align (
        .mem_data (mem_data_r),
        .addr     (mem_addr_r),
        .size     (mem_size_r),
        .sext     (mem_sext_r),
        .aligned  (aligned_s)
    );

    // Write-back source select from the registered instruction.
    always_comb begin
        wb_data_s = '0;
        case (wb_sel_r)
            WB_SEL_ALU:  wb_data_s = alu_res_r;
            WB_SEL_MEM:  wb_data_s = aligned_s;
            WB_SEL_LINK: wb_data_s = pc_r + DATA_W'(LINK_OFFSET);
            WB_SEL_RSVD: wb_data_s = '0;
            default:     wb_data_s = '0;
        endcase
    end

    // Outputs depend only on registers, so the async reset clears them at once.
    assign rf_w_en     = valid_r & reg_we_r & (rd_r != 5'd0);
    assign fwd_valid   = rf_w_en;
    assign rf_req_w    = rd_r;
    assign rf_data_w   = wb_data_s;
    assign retired_cnt = cnt_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: per-cycle scoreboard against a transaction model plus literal checks.
module tb_wb_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en, stall, flush;
    logic              in_valid, in_reg_we, in_mem_sext, in_halt;
    logic [4:0]        in_rd;
    logic [1:0]        in_wb_sel, in_mem_addr, in_mem_size;
    logic [DATA_W-1:0] in_alu_res, in_mem_data, in_pc;
    logic              rf_w_en, fwd_valid, halted;
    logic [4:0]        rf_req_w;
    logic [DATA_W-1:0] rf_data_w;
    logic [CNT_W-1:0]  retired_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    // Model: what the instruction now in WB must write, plus counter and halt status.
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_cnt;
    bit          m_halted;

    wb_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W), .LINK_OFFSET(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_we(in_reg_we), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
        .in_alu_res(in_alu_res), .in_mem_data(in_mem_data), .in_mem_addr(in_mem_addr),
        .in_mem_size(in_mem_size), .in_mem_sext(in_mem_sext), .in_pc(in_pc), .in_halt(in_halt),
        .rf_w_en(rf_w_en), .rf_req_w(rf_req_w), .rf_data_w(rf_data_w), .fwd_valid(fwd_valid),
        .retired_cnt(retired_cnt), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wb_value(input logic [1:0] sel, input logic [31:0] alu,
            input logic [31:0] mem, input logic [1:0] addr, input logic [1:0] size,
            input logic sext, input logic [31:0] pc);
        logic [31:0] v;
        v = 32'd0;
        if (sel == 2'd0) v = alu;
        else if (sel == 2'd2) v = pc + 32'd8;
        else if (sel == 2'd1) begin
            if (size >= 2'd2) v = mem;
            else if (size == 2'd0) begin
                v = (mem >> (32'(addr) * 32'd8)) & 32'hFF;
                if (sext && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end else begin
                v = (addr >= 2'd2) ? (mem >> 16) : (mem & 32'hFFFF);
                if (sext && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model update at each capture edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_we <= 1'b0; m_rd <= 5'd0; m_data <= 32'd0; m_cnt <= 0; m_halted <= 1'b0;
        end else if (en && !m_halted) begin
            if (flush) m_we <= 1'b0;
            else if (!stall) begin
                m_we   <= in_valid && in_reg_we && (in_rd != 5'd0);
                m_rd   <= in_rd;
                m_data <= wb_value(in_wb_sel, in_alu_res, in_mem_data, in_mem_addr,
                                   in_mem_size, in_mem_sext, in_pc);
                if (in_valid) m_cnt <= (m_cnt + 1) % (1 << CNT_W);
                if (in_valid && in_halt) m_halted <= 1'b1;
            end
        end
    end

    // Per-cycle scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("sb_w_en", {31'd0, rf_w_en}, {31'd0, m_we});
            check("sb_fwd_valid", {31'd0, fwd_valid}, {31'd0, m_we});
            check("sb_cnt", {28'd0, retired_cnt}, 32'(m_cnt));
            check("sb_halted", {31'd0, halted}, {31'd0, m_halted});
            if (m_we) begin
                check("sb_rd", {27'd0, rf_req_w}, {27'd0, m_rd});
                check("sb_data", rf_data_w, m_data);
            end
        end
    end

    task automatic idle();
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_reg_we = 1'b0; in_halt = 1'b0;
        in_rd = 5'd0; in_wb_sel = 2'd0; in_alu_res = 32'd0; in_mem_data = 32'd0;
        in_mem_addr = 2'd0; in_mem_size = 2'd0; in_mem_sext = 1'b0; in_pc = 32'd0;
    endtask

    task automatic set_in(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
            input logic [31:0] mem, input logic [1:0] addr, input logic [1:0] size,
            input logic sext, input logic [31:0] pc, input logic halt);
        in_valid = 1'b1; in_reg_we = 1'b1; in_rd = rd; in_wb_sel = sel; in_alu_res = alu;
        in_mem_data = mem; in_mem_addr = addr; in_mem_size = size; in_mem_sext = sext;
        in_pc = pc; in_halt = halt;
    endtask

    // Present one instruction for exactly one capture edge; returns #1 after that edge.
    task automatic issue(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
            input logic [31:0] mem, input logic [1:0] addr, input logic [1:0] size,
            input logic sext, input logic [31:0] pc, input logic halt);
        set_in(rd, sel, alu, mem, addr, size, sext, pc, halt);
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        check("reset_w_en", {31'd0, rf_w_en}, 32'd0);
        check("reset_data", rf_data_w, 32'd0);
        check("reset_cnt", {28'd0, retired_cnt}, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        rst_n = 1'b1;
        chk_on = 1'b1;
        #1;

        // ALU write-back
        issue(5'd5, 2'd0, 32'h1234_5678, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0);
        check("alu_w_en", {31'd0, rf_w_en}, 32'd1);
        check("alu_rd", {27'd0, rf_req_w}, 32'd5);
        check("alu_data", rf_data_w, 32'h1234_5678);
        check("alu_cnt", {28'd0, retired_cnt}, 32'd1);

        // Loads from 0x80FF7F01
        issue(5'd6, 2'd1, 32'd0, 32'h80FF_7F01, 2'd3, 2'd0, 1'b1, 32'd0, 1'b0);
        check("lb_a3_sext", rf_data_w, 32'hFFFF_FF80);
        issue(5'd6, 2'd1, 32'd0, 32'h80FF_7F01, 2'd2, 2'd0, 1'b0, 32'd0, 1'b0);
        check("lbu_a2", rf_data_w, 32'h0000_00FF);
        issue(5'd6, 2'd1, 32'd0, 32'h80FF_7F01, 2'd2, 2'd1, 1'b1, 32'd0, 1'b0);
        check("lh_a2_sext", rf_data_w, 32'hFFFF_80FF);
        issue(5'd6, 2'd1, 32'd0, 32'h80FF_7F01, 2'd1, 2'd1, 1'b1, 32'd0, 1'b0);
        check("lh_a1_sext", rf_data_w, 32'h0000_7F01);
        issue(5'd6, 2'd1, 32'd0, 32'h80FF_7F01, 2'd3, 2'd3, 1'b0, 32'd0, 1'b0);
        check("lw_size3", rf_data_w, 32'h80FF_7F01);

        // Write to r0 is suppressed but still retires
        issue(5'd0, 2'd0, 32'hDEAD_BEEF, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0);
        check("r0_w_en", {31'd0, rf_w_en}, 32'd0);
        check("r0_fwd", {31'd0, fwd_valid}, 32'd0);
        check("r0_cnt", {28'd0, retired_cnt}, 32'd7);

        // Stall holds contents and the counter
        issue(5'd9, 2'd0, 32'h0000_0055, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0);
        set_in(5'd10, 2'd0, 32'h0000_0066, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0);
        stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("stall_rd", {27'd0, rf_req_w}, 32'd9);
        check("stall_data", rf_data_w, 32'h0000_0055);
        check("stall_cnt", {28'd0, retired_cnt}, 32'd8);
        flush = 1'b1;
        @(posedge clk); #1;
        check("stall_flush_w_en", {31'd0, rf_w_en}, 32'd0);
        check("stall_flush_cnt", {28'd0, retired_cnt}, 32'd8);
        idle();

        // en=0 freezes everything
        en = 1'b0;
        set_in(5'd11, 2'd0, 32'h0000_0077, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("en0_cnt", {28'd0, retired_cnt}, 32'd8);
        check("en0_halted", {31'd0, halted}, 32'd0);
        idle();
        en = 1'b1;

        // Counter wrap (4-bit counter here)
        for (int i = 0; i < 40 && m_cnt != 15; i++)
            issue(5'd1, 2'd0, 32'(i), 32'd0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0);
        check("pre_wrap_cnt", {28'd0, retired_cnt}, 32'd15);
        issue(5'd2, 2'd0, 32'h0000_0001, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0);
        check("wrap_cnt", {28'd0, retired_cnt}, 32'd0);

        // LINK wraps modulo 2^32
        issue(5'd31, 2'd2, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'hFFFF_FFFC, 1'b0);
        check("link_data", rf_data_w, 32'h0000_0004);
        issue(5'd3, 2'd3, 32'h1111_1111, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0);
        check("rsvd_data", rf_data_w, 32'd0);

        // Halt captures, keeps its write, then freezes
        issue(5'd7, 2'd0, 32'h0000_00AA, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b1);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_cnt", {28'd0, retired_cnt}, 32'd3);
        check("halt_data", rf_data_w, 32'h0000_00AA);
        for (int i = 0; i < 3; i++)
            issue(5'(12 + i), 2'd0, 32'(i), 32'd0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0);
        check("frozen_rd", {27'd0, rf_req_w}, 32'd7);
        check("frozen_cnt", {28'd0, retired_cnt}, 32'd3);
        check("frozen_halted", {31'd0, halted}, 32'd1);

        // Mid-cycle async reset takes effect before the next edge
        @(posedge clk); #2;
        chk_on = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_halted", {31'd0, halted}, 32'd0);
        check("arst_w_en", {31'd0, rf_w_en}, 32'd0);
        check("arst_rd", {27'd0, rf_req_w}, 32'd0);
        check("arst_data", rf_data_w, 32'd0);
        check("arst_cnt", {28'd0, retired_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
